ring_osc_sync: RTL

Parametrised, clock-synchronous ring-oscillator model for digital-only simulation of the mixed-signal oscillator examples. It is a loop of `STAGES` inverting stages. Each stage has a programmable inertial delay counted in clock cycles. The block adds run control, a pause input, and an oscillation-cycle counter with automatic stop after a programmed number of cycles. It replaces free-running `#delay` inverter chains, so the design can be synthesised and checked cycle-exactly.

---
 rtl/ring_osc_sync.sv | 92 +++++++++
 1 files changed

// File: rtl/ring_osc_sync.sv
// ring_osc_sync: clock-synchronous inverting ring oscillator with run control, pause and cycle-limited stop
// Ports: clk/rst_n (async active-low) clock and reset; en run request; hold pause while running;
// delay per-stage delay in clocks (0 acts as 1, latched on run entry); max_cycles stop count (0 = unlimited);
// taps stage outputs; osc_out = taps[0]; cycles osc_out rises since run entry; running/done state decodes.
module ring_osc_sync #(
  parameter int STAGES  = 5,
  parameter int DELAY_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               hold,
  input  logic [DELAY_W-1:0] delay,
  input  logic [CNT_W-1:0]   max_cycles,
  output logic [STAGES-1:0]  taps,
  output logic               osc_out,
  output logic [CNT_W-1:0]   cycles,
  output logic               running,
  output logic               done
);
  if (STAGES < 3 || STAGES > 31 || STAGES % 2 == 0) begin : g_bad_stages
    $fatal(1, "ring_osc_sync: STAGES must be odd and in 3..31");
  end
  // alternating 0,1,0,...: with an odd ring only stage 0 starts unstable, so a single edge circulates
  localparam logic [31:0] ALT = 32'haaaa_aaaa;
  localparam logic [STAGES-1:0] INIT = ALT[STAGES-1:0];
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [STAGES-1:0]    taps_q, taps_d, prev;
  logic [DELAY_W-1:0]   d_lat_q, d_lat_d;
  logic [DELAY_W-1:0]   tmr_q [STAGES];
  logic [DELAY_W-1:0]   tmr_d [STAGES];
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 running_q, done_q;
  assign prev = {taps_q[STAGES-2:0], taps_q[STAGES-1]};
  always_comb begin
    state_d  = state_q;
    taps_d   = taps_q;
    tmr_d    = tmr_q;
    d_lat_d  = d_lat_q;
    cycles_d = cycles_q;
    if (state_q == IDLE) begin
      taps_d = INIT;
      tmr_d  = '{default: '0};
      if (en) begin
        state_d  = RUN;
        d_lat_d  = (delay == '0) ? DELAY_W'(1) : delay;
        cycles_d = '0;
      end
    end else if (!en) begin
      state_d = IDLE;
      taps_d  = INIT;
      tmr_d   = '{default: '0};
    end else if (state_q == RUN && !hold) begin
      // a stage whose input equals its output must stay so for d_lat clocks before it flips
      for (int i = 0; i < STAGES; i++) begin
        if (taps_q[i] != prev[i]) tmr_d[i] = '0;
        else if (tmr_q[i] == d_lat_q - DELAY_W'(1)) begin
          taps_d[i] = ~taps_q[i];
          tmr_d[i]  = '0;
        end else tmr_d[i] = tmr_q[i] + DELAY_W'(1);
      end
      if (!taps_q[0] && taps_d[0] && !(&cycles_q)) cycles_d = cycles_q + CNT_W'(1);
      if (max_cycles != '0 && cycles_d == max_cycles) state_d = DONE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      taps_q    <= INIT;
      tmr_q     <= '{default: '0};
      d_lat_q   <= DELAY_W'(1);
      cycles_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      taps_q    <= taps_d;
      tmr_q     <= tmr_d;
      d_lat_q   <= d_lat_d;
      cycles_q  <= cycles_d;
      running_q <= state_d == RUN;
      done_q    <= state_d == DONE;
    end
  end
  assign taps    = taps_q;
  assign osc_out = taps_q[0];
  assign cycles  = cycles_q;
  assign running = running_q;
  assign done    = done_q;
endmodule
